// File: rtl/shl_pkg.sv
// Shared types and constants for the iterative shift-left unit.
package shl_pkg;

    localparam int SHL_WIDTH   = 32;
    localparam int SHL_CNT_W   = 6;
    localparam int SHL_MAX_CNT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shl_state_e;

    // Logical shifts past the word width all produce zero, so clamp there;
    // rotates are periodic in the width, so only the low five bits matter.
    function automatic logic [SHL_CNT_W-1:0] shl_count(input logic [SHL_WIDTH-1:0] n,
                                                       input logic rot);
        if (rot)
            return {1'b0, n[4:0]};
        else if (|n[SHL_WIDTH-1:5])
            return SHL_CNT_W'(SHL_MAX_CNT);
        else
            return {1'b0, n[4:0]};
    endfunction

endpackage

// File: rtl/shl32_iter_if.sv
// Request/response bundle between the control unit (master) and shl32_iter (slave).
interface shl32_iter_if;
    import shl_pkg::*;

    logic                 start;
    logic [SHL_WIDTH-1:0] in;
    logic [SHL_WIDTH-1:0] num_shifts;
    logic                 rotate;
    logic [SHL_WIDTH-1:0] out;
    logic                 busy;
    logic                 done;

    modport master (output start, in, num_shifts, rotate,
                    input  out, busy, done);
    modport slave  (input  start, in, num_shifts, rotate,
                    output out, busy, done);
endinterface

// File: rtl/shl32_step.sv
// Single-bit left shift / rotate of the work word. Rotate fill exists only
// when SHL_ROTATE_EN is defined; otherwise the fill bit is always zero.
module shl32_step
    import shl_pkg::*;
(
    input  logic [SHL_WIDTH-1:0] value_i,
    input  logic                 mode_i,
    output logic [SHL_WIDTH-1:0] next_o
);

`ifdef SHL_ROTATE_EN
    logic fill;
    assign fill   = mode_i & value_i[SHL_WIDTH-1];
    assign next_o = {value_i[SHL_WIDTH-2:0], fill};
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign next_o      = {value_i[SHL_WIDTH-2:0], 1'b0};
`endif

endmodule

// File: rtl/shl32_iter.sv
// Iterative 32-bit shift-left unit, one bit per clock with a done pulse.
// Rotate-left mode is available only when SHL_ROTATE_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | shifting one bit per cycle, busy high
// ST_DONE  | result valid in out, done high for one cycle
module shl32_iter
    import shl_pkg::*;
(
    input  logic         clk,
    input  logic         clr,
    shl32_iter_if.slave  bus
);

    shl_state_e           state_q;
    logic [SHL_WIDTH-1:0] work_q;
    logic [SHL_CNT_W-1:0] cnt_q;
    logic                 mode_q;
    logic [SHL_WIDTH-1:0] out_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 rot_d;
    logic [SHL_CNT_W-1:0] cnt_d;
    logic [SHL_WIDTH-1:0] work_d;

`ifdef SHL_ROTATE_EN
    assign rot_d = bus.rotate;
`else
    logic unused_rotate;
    assign unused_rotate = bus.rotate;
    assign rot_d         = 1'b0;
`endif

    assign cnt_d = shl_count(bus.num_shifts, rot_d);

    shl32_step u_step (
        .value_i (work_q),
        .mode_i  (mode_q),
        .next_o  (work_d)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (bus.start) begin
                        work_q <= bus.in;
                        mode_q <= rot_d;
                        cnt_q  <= cnt_d;
                        if (cnt_d == '0) begin
                            out_q   <= bus.in;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - SHL_CNT_W'(1);
                    if (cnt_q == SHL_CNT_W'(1)) begin
                        out_q   <= work_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shl32_iter.sv
// Randomized and directed bench for shl32_iter against an arithmetic reference model.
module tb_shl32_iter;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_prev;

    shl32_iter_if bus ();

    shl32_iter dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int ref_count(input logic [31:0] n, input logic r);
        logic rot_on;
`ifdef SHL_ROTATE_EN
        rot_on = r;
`else
        rot_on = 1'b0;
`endif
        if (rot_on) return int'(n % 32);
        return (n > 32) ? 32 : int'(n);
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] n,
                                               input logic r);
        logic        rot_on;
        logic [63:0] dbl;
        int          k;
`ifdef SHL_ROTATE_EN
        rot_on = r;
`else
        rot_on = 1'b0;
`endif
        k = ref_count(n, r);
        if (rot_on) begin
            dbl = {a, a} << k;
            return dbl[63:32];
        end
        if (k >= 32) return 32'h0;
        return a << k;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] n, input logic r);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.in         = a;
        bus.num_shifts = n;
        bus.rotate     = r;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called one step after an accepting edge; expects done after exp_k more edges.
    task automatic wait_done(input int exp_k, input logic [31:0] exp_out, input string tag);
        int k = 0;
        int busy_cnt = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            chk({tag, "_out_hold"}, bus.out, exp_prev);
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, "_latency"}, 32'(k), 32'(exp_k));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_k));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_out"}, bus.out, exp_out);
        exp_prev = exp_out;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] n, input logic r,
                         input string tag);
        launch(a, n, r);
        wait_done(ref_count(n, r), ref_result(a, n, r), tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int saw_done;
        logic [31:0] ra, rn;
        logic        rr;

        n_tests        = 0;
        n_fail         = 0;
        exp_prev       = 32'h0;
        bus.start      = 1'b0;
        bus.in         = 32'h0;
        bus.num_shifts = 32'h0;
        bus.rotate     = 1'b0;
        clr            = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", bus.out, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        do_op(32'h0000_0001, 32'd4, 1'b0, "shl4");
        do_op(32'hDEAD_BEEF, 32'd0, 1'b0, "zero");
        do_op(32'hFFFF_FFFF, 32'd40, 1'b0, "clamp40");
        do_op(32'h8000_0001, 32'd1, 1'b1, "rot1");
        do_op(32'h8000_0001, 32'd33, 1'b1, "rot33");
        do_op(32'h1234_5678, 32'd31, 1'b0, "shl31");
        do_op(32'h1234_5678, 32'd32, 1'b0, "shl32");
        do_op(32'hA5A5_0F0F, 32'h8000_0002, 1'b0, "upper_bit");

        // Start during SHIFT is dropped, then a start in the done cycle is taken.
        launch(32'h1, 32'd8, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        bus.start = 1'b1;
        bus.in    = 32'hF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(5, 32'h0000_0100, "ignore");
        bus.start      = 1'b1;
        bus.in         = 32'h3;
        bus.num_shifts = 32'd1;
        bus.rotate     = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(1, 32'h0000_0006, "b2b");

        // Asynchronous clear mid-operation.
        launch(32'h1, 32'd10, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        clr = 1'b0;
        #1;
        chk("clr_busy", 32'(bus.busy), 32'd0);
        chk("clr_done", 32'(bus.done), 32'd0);
        chk("clr_out", bus.out, 32'h0);
        exp_prev = 32'h0;
        @(negedge clk);
        clr = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1;
        end
        chk("clr_no_done", 32'(saw_done), 32'd0);
        do_op(32'h0000_0007, 32'd3, 1'b0, "post_clr");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rn = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 35));
            rr = 1'($urandom_range(0, 1));
            do_op(ra, rn, rr, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
